// File: rtl/cbc_chain_ctrl_if.sv
// Stream, cipher-core and status signals of the CBC chaining controller.
// The controller takes the slave view; the environment drives the master view.
`timescale 1ns/1ps
interface cbc_chain_ctrl_if #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned CNT_W   = 32
);
    logic               start;
    logic               mode;
    logic [BLOCK_W-1:0] iv;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               in_last;
    logic               core_start;
    logic [BLOCK_W-1:0] core_din;
    logic               core_done;
    logic [BLOCK_W-1:0] core_dout;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               out_last;
    logic               busy;
    logic [CNT_W-1:0]   blk_cnt;

    modport slave (
        input  start, mode, iv, in_valid, in_data, in_last, core_done, core_dout, out_ready,
        output in_ready, core_start, core_din, out_valid, out_data, out_last, busy, blk_cnt
    );

    modport master (
        output start, mode, iv, in_valid, in_data, in_last, core_done, core_dout, out_ready,
        input  in_ready, core_start, core_din, out_valid, out_data, out_last, busy, blk_cnt
    );
endinterface

// File: rtl/cbc_chain_ctrl.sv
// CBC chaining controller: moves one message block at a time through the XOR stage
// and an external cipher core, owning the chain register, block counter and handshakes.
`timescale 1ns/1ps
module cbc_chain_ctrl #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned CNT_W   = 32
) (
    input logic             clk,
    input logic             rst,
    cbc_chain_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitIn,
        StCoreReq,
        StCoreWait,
        StOutput
    } state_e;

    state_e             r_state;
    logic               r_mode;
    logic               r_last;
    logic [BLOCK_W-1:0] r_chain;
    logic [BLOCK_W-1:0] r_ct_hold;
    logic [BLOCK_W-1:0] r_core_din;
    logic [BLOCK_W-1:0] r_out_data;
    logic               r_in_ready;
    logic               r_core_start;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_busy;
    logic [CNT_W-1:0]   r_blk_cnt;

    logic w_in_hs;
    logic w_out_hs;

    assign w_in_hs  = (r_state == StWaitIn) && r_in_ready && bus.in_valid;
    assign w_out_hs = (r_state == StOutput) && r_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_mode       <= 1'b0;
            r_last       <= 1'b0;
            r_chain      <= '0;
            r_ct_hold    <= '0;
            r_core_din   <= '0;
            r_out_data   <= '0;
            r_in_ready   <= 1'b0;
            r_core_start <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_blk_cnt    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_chain    <= bus.iv;
                        r_mode     <= bus.mode;
                        r_blk_cnt  <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= StWaitIn;
                    end
                end
                StWaitIn: begin
                    if (w_in_hs) begin
                        r_ct_hold    <= bus.in_data;
                        r_last       <= bus.in_last;
                        r_core_din   <= r_mode ? bus.in_data : (bus.in_data ^ r_chain);
                        r_in_ready   <= 1'b0;
                        r_core_start <= 1'b1;
                        r_state      <= StCoreReq;
                    end
                end
                StCoreReq: begin
                    r_core_start <= 1'b0;
                    r_state      <= StCoreWait;
                end
                StCoreWait: begin
                    // Decrypt chains on the held ciphertext, not on the core result.
                    if (bus.core_done) begin
                        if (r_mode) begin
                            r_out_data <= bus.core_dout ^ r_chain;
                            r_chain    <= r_ct_hold;
                        end else begin
                            r_out_data <= bus.core_dout;
                            r_chain    <= bus.core_dout;
                        end
                        r_out_last  <= r_last;
                        r_out_valid <= 1'b1;
                        r_state     <= StOutput;
                    end
                end
                StOutput: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_blk_cnt   <= r_blk_cnt + CNT_W'(1);
                        if (r_last) begin
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= StWaitIn;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.core_start = r_core_start;
    assign bus.core_din   = r_core_din;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign bus.busy       = r_busy;
    assign bus.blk_cnt    = r_blk_cnt;

endmodule

// File: tb/tb_cbc_chain_ctrl.sv
// Scoreboard bench for cbc_chain_ctrl: expected core operands and outputs are queued
// at each input handshake and compared by a monitor; a second instance uses CNT_W=2.
`timescale 1ns/1ps
module tb_cbc_chain_ctrl;

    localparam int unsigned BW = 128;
    localparam logic [BW-1:0] K = {16{8'h5A}};

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
        logic [31:0]   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cbc_chain_ctrl_if #(.BLOCK_W(BW), .CNT_W(32)) bus_a ();
    cbc_chain_ctrl_if #(.BLOCK_W(BW), .CNT_W(2))  bus_b ();

    assign bus_b.start     = bus_a.start;
    assign bus_b.mode      = bus_a.mode;
    assign bus_b.iv        = bus_a.iv;
    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.in_last   = bus_a.in_last;
    assign bus_b.core_done = bus_a.core_done;
    assign bus_b.core_dout = bus_a.core_dout;
    assign bus_b.out_ready = bus_a.out_ready;

    cbc_chain_ctrl #(.BLOCK_W(BW), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    cbc_chain_ctrl #(.BLOCK_W(BW), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int            n_chk  = 0;
    int            n_pass = 0;
    exp_t          out_q[$];
    logic [BW-1:0] din_q[$];
    logic [BW-1:0] chain_m;
    logic          mode_m;
    logic [31:0]   m_cnt;
    bit            abort    = 1'b0;
    bit            spur_req = 1'b0;
    logic [BW-1:0] c0, c1;

    function automatic logic [BW-1:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_eq(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    task automatic model_push(input logic [BW-1:0] d, input logic last);
        logic [BW-1:0] din;
        logic [BW-1:0] dout;
        exp_t          e;
        if (!mode_m) begin
            din     = d ^ chain_m;
            dout    = din ^ K;
            chain_m = dout;
        end else begin
            din     = d;
            dout    = (d ^ K) ^ chain_m;
            chain_m = d;
        end
        m_cnt++;
        e.data = dout;
        e.last = last;
        e.cnt  = m_cnt;
        din_q.push_back(din);
        out_q.push_back(e);
    endtask

    // Core: result = operand ^ K, done pulse three cycles after core_start.
    task automatic core_model();
        int            cd      = 0;
        bit            chk_nxt = 1'b0;
        logic [BW-1:0] held    = '0;
        forever begin
            @(negedge clk);
            if (chk_nxt) begin
                check_eq("out_valid_after_done", bus_a.out_valid, 1);
                chk_nxt = 1'b0;
            end
            bus_a.core_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus_a.core_done = 1'b1;
                    bus_a.core_dout = held ^ K;
                    chk_nxt         = !abort;
                end
            end
            if (bus_a.core_start) begin
                held = bus_a.core_din;
                cd   = 3;
            end
            if (spur_req) begin
                bus_a.core_done = 1'b1;
                bus_a.core_dout = rand_blk();
                spur_req        = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        bit   pend = 1'b0;
        exp_t pe   = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check_eq("blk_cnt", bus_a.blk_cnt, pe.cnt);
                check_eq("blk_cnt_w2", bus_b.blk_cnt, pe.cnt[1:0]);
                if (pe.last) check_eq("busy_low_after_last", bus_a.busy, 0);
                else         check_eq("in_ready_after_out", bus_a.in_ready, 1);
                pend = 1'b0;
            end
            if (bus_a.core_start) begin
                if (din_q.size() == 0) check_eq("core_start_unexpected", 1, 0);
                else check_eq("core_din", bus_a.core_din, din_q.pop_front());
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (out_q.size() == 0) begin
                    check_eq("out_unexpected", 1, 0);
                end else begin
                    pe = out_q.pop_front();
                    check_eq("out_data", bus_a.out_data, pe.data);
                    check_eq("out_last", bus_a.out_last, pe.last);
                    check_eq("out_valid_w2", bus_b.out_valid, 1);
                    check_eq("out_data_w2", bus_b.out_data, pe.data);
                    pend = 1'b1;
                end
            end
        end
    endtask

    task automatic start_msg(input logic m, input logic [BW-1:0] v);
        @(posedge clk); #1;
        bus_a.start = 1'b1;
        bus_a.mode  = m;
        bus_a.iv    = v;
        chain_m     = v;
        mode_m      = m;
        m_cnt       = 0;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        bus_a.mode  = ~m;
        bus_a.iv    = ~v;
    endtask

    task automatic send_block(input logic [BW-1:0] d, input logic last);
        bit hs = 1'b0;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        bus_a.in_last  = last;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                hs = 1'b1;
                model_push(d, last);
            end
            @(posedge clk); #1;
        end
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = rand_blk();
        bus_a.in_last  = 1'b0;
        if (!hs) begin
            check_eq("in_handshake_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check_eq("core_start_next_cycle", bus_a.core_start, 1);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!bus_a.busy && out_q.size() == 0) done = 1'b1;
        end
        if (!done) check_eq("idle_timeout", 0, 1);
    endtask

    initial begin
        bit seen;
        bus_a.start     = 1'b0;
        bus_a.mode      = 1'b0;
        bus_a.iv        = '0;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.in_last   = 1'b0;
        bus_a.core_done = 1'b0;
        bus_a.core_dout = '0;
        bus_a.out_ready = 1'b1;
        fork
            monitor();
            core_model();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", bus_a.in_ready, 0);
        check_eq("rst_core_start", bus_a.core_start, 0);
        check_eq("rst_out_valid", bus_a.out_valid, 0);
        check_eq("rst_busy", bus_a.busy, 0);
        check_eq("rst_blk_cnt", bus_a.blk_cnt, 0);
        check_eq("rst_core_din", bus_a.core_din, 0);

        // One-block encrypt.
        start_msg(1'b0, {16{8'h0F}});
        send_block({16{8'hFF}}, 1'b1);
        wait_idle();

        // Two-block encrypt with output backpressure on block 0.
        start_msg(1'b0, '0);
        bus_a.out_ready = 1'b0;
        send_block(128'h1, 1'b0);
        c0   = chain_m;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus_a.out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check_eq("stall_out_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_out_valid", bus_a.out_valid, 1);
            check_eq("stall_out_data", bus_a.out_data, c0);
            check_eq("stall_in_ready", bus_a.in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus_a.out_ready = 1'b1;
        send_block(128'h2, 1'b1);
        c1 = chain_m;
        wait_idle();
        check_eq("enc_chain_end", dut_a.r_chain, c1);

        // Decrypt the two ciphertexts back.
        start_msg(1'b1, '0);
        send_block(c0, 1'b0);
        send_block(c1, 1'b1);
        wait_idle();
        check_eq("dec_chain_end", dut_a.r_chain, c1);

        // start pulsed during CORE_WAIT is ignored.
        start_msg(1'b0, rand_blk());
        send_block(rand_blk(), 1'b0);
        @(posedge clk); #1;
        bus_a.start = 1'b1;
        bus_a.iv    = rand_blk();
        bus_a.mode  = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        send_block(rand_blk(), 1'b1);
        wait_idle();

        // Spurious core_done while waiting for input.
        start_msg(1'b1, rand_blk());
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.in_ready) seen = 1'b1;
        end
        if (!seen) check_eq("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        spur_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("spur_out_valid", bus_a.out_valid, 0);
        end
        send_block(rand_blk(), 1'b1);
        wait_idle();

        // Reset during CORE_WAIT; the late core_done must be ignored.
        start_msg(1'b0, rand_blk());
        send_block(rand_blk(), 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        din_q.delete();
        out_q.delete();
        @(negedge clk);
        check_eq("abort_in_ready", bus_a.in_ready, 0);
        check_eq("abort_core_start", bus_a.core_start, 0);
        check_eq("abort_out_valid", bus_a.out_valid, 0);
        check_eq("abort_out_last", bus_a.out_last, 0);
        check_eq("abort_out_data", bus_a.out_data, 0);
        check_eq("abort_core_din", bus_a.core_din, 0);
        check_eq("abort_busy", bus_a.busy, 0);
        check_eq("abort_blk_cnt", bus_a.blk_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("abort_late_done", bus_a.out_valid, 0);
        end
        abort = 1'b0;

        // Five-block message: the CNT_W=2 instance wraps its counter.
        start_msg(1'b0, rand_blk());
        for (int i = 0; i < 5; i++) send_block(rand_blk(), i == 4);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
